// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, sync/blank
// decode, and a configurable delay line aligning sync/blank with pipelined pixel data.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int PIPE_DELAY = 2,
    parameter int COORD_W    = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_active,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_blank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > (1 << COORD_W)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in COORD_W bits");
    end
    if (V_TOTAL > (1 << COORD_W)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in COORD_W bits");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_pipe_delay
        $error("vga_timing_gen: PIPE_DELAY must be in 0..15");
    end

    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               active_raw;
    logic               hs_raw, vs_raw, blank_raw;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (i_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign o_x = h_cnt_q;
    assign o_y = v_cnt_q;

    // Strobes are gated by reset so the pixel source sees nothing while held.
    assign active_raw    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign o_active      = i_rst && active_raw;
    assign o_line_start  = i_rst && (h_cnt_q == '0);
    assign o_frame_start = o_line_start && (v_cnt_q == '0);

    assign hs_raw    = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? H_POL : ~H_POL;
    assign vs_raw    = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? V_POL : ~V_POL;
    assign blank_raw = ~o_active;

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign o_hsync = hs_raw;
        assign o_vsync = vs_raw;
        assign o_blank = blank_raw;
    end else begin : g_delay
        localparam logic [2:0] RST_WORD = {~H_POL, ~V_POL, 1'b1};

        logic [2:0] pipe_q [PIPE_DELAY];
        logic [2:0] pipe_d [PIPE_DELAY];

        always_comb begin
            pipe_d = pipe_q;
            if (i_en) begin
                pipe_d[0] = {hs_raw, vs_raw, blank_raw};
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    pipe_q[i] <= RST_WORD;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign {o_hsync, o_vsync, o_blank} = pipe_q[PIPE_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three builds (default PIPE_DELAY=2, default with
// PIPE_DELAY=0, tiny positive-polarity raster with PIPE_DELAY=3) against a linear-position model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic iRst = 1'b0;
    logic iEn = 1'b0;

    always #5 clk = ~clk;

    logic [11:0] aX, aY, bX, bY;
    logic [5:0]  cX, cY;
    logic aAct, aLs, aFs, aHs, aVs, aBl;
    logic bAct, bLs, bFs, bHs, bVs, bBl;
    logic cAct, cLs, cFs, cHs, cVs, cBl;

    vga_timing_gen #(.PIPE_DELAY(2)) dutA (
        .i_clk(clk), .i_rst(iRst), .i_en(iEn), .o_x(aX), .o_y(aY),
        .o_active(aAct), .o_line_start(aLs), .o_frame_start(aFs),
        .o_hsync(aHs), .o_vsync(aVs), .o_blank(aBl));

    vga_timing_gen #(.PIPE_DELAY(0)) dutB (
        .i_clk(clk), .i_rst(iRst), .i_en(iEn), .o_x(bX), .o_y(bY),
        .o_active(bAct), .o_line_start(bLs), .o_frame_start(bFs),
        .o_hsync(bHs), .o_vsync(bVs), .o_blank(bBl));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(3), .COORD_W(6)) dutC (
        .i_clk(clk), .i_rst(iRst), .i_en(iEn), .o_x(cX), .o_y(cY),
        .o_active(cAct), .o_line_start(cLs), .o_frame_start(cFs),
        .o_hsync(cHs), .o_vsync(cVs), .o_blank(cBl));

    logic [29:0] actA, actB, actC;
    assign actA = {aX, aY, aAct, aLs, aFs, aHs, aVs, aBl};
    assign actB = {bX, bY, bAct, bLs, bFs, bHs, bVs, bBl};
    assign actC = {6'd0, cX, 6'd0, cY, cAct, cLs, cFs, cHs, cVs, cBl};

    int cHA[3]  = '{640, 640, 16};
    int cHFP[3] = '{16, 16, 2};
    int cHS[3]  = '{96, 96, 4};
    int cHBP[3] = '{48, 48, 3};
    int cVA[3]  = '{480, 480, 8};
    int cVFP[3] = '{10, 10, 2};
    int cVS[3]  = '{2, 2, 2};
    int cVBP[3] = '{33, 33, 3};
    bit cHP[3]  = '{1'b0, 1'b0, 1'b1};
    bit cVP[3]  = '{1'b0, 1'b0, 1'b1};
    int cPD[3]  = '{2, 0, 3};

    // Model state: linear pixel position in the frame, plus a log of raw sync words by enabled step.
    int pos[3];
    int stepCnt[3];
    int sinceRst[3];
    logic [2:0] rawLog[3][16];

    logic [29:0] expQA[$];
    logic [29:0] expQB[$];
    logic [29:0] expQC[$];

    int testsRun = 0;
    int testsFailed = 0;
    int cycleNum = 0;

    function automatic int hTot(int k);
        return cHA[k] + cHFP[k] + cHS[k] + cHBP[k];
    endfunction

    function automatic int vTot(int k);
        return cVA[k] + cVFP[k] + cVS[k] + cVBP[k];
    endfunction

    function automatic logic [2:0] rawOf(int k, int p, bit rstn);
        int x, y;
        bit act, hs, vs;
        x = p % hTot(k);
        y = p / hTot(k);
        act = rstn && (x < cHA[k]) && (y < cVA[k]);
        hs = (x >= cHA[k] + cHFP[k] && x < cHA[k] + cHFP[k] + cHS[k]) ? cHP[k] : !cHP[k];
        vs = (y >= cVA[k] + cVFP[k] && y < cVA[k] + cVFP[k] + cVS[k]) ? cVP[k] : !cVP[k];
        return {hs, vs, !act};
    endfunction

    function automatic logic [29:0] expectOf(int k, bit rstn);
        int x, y;
        logic [2:0] sync;
        x = pos[k] % hTot(k);
        y = pos[k] / hTot(k);
        if (cPD[k] == 0)
            sync = rawOf(k, pos[k], rstn);
        else if (sinceRst[k] < cPD[k])
            sync = {!cHP[k], !cVP[k], 1'b1};
        else
            sync = rawLog[k][(stepCnt[k] - cPD[k]) % 16];
        return {12'(x), 12'(y),
                rstn && (x < cHA[k]) && (y < cVA[k]),
                rstn && (x == 0),
                rstn && (pos[k] == 0),
                sync};
    endfunction

    task automatic modelStep(bit en, bit rstn);
        for (int k = 0; k < 3; k++) begin
            if (!rstn) begin
                pos[k] = 0;
                sinceRst[k] = 0;
            end else if (en) begin
                rawLog[k][stepCnt[k] % 16] = rawOf(k, pos[k], 1'b1);
                stepCnt[k]++;
                sinceRst[k]++;
                pos[k] = (pos[k] + 1) % (hTot(k) * vTot(k));
            end
        end
    endtask

    task automatic applyStimulus(bit en, bit rstn);
        @(negedge clk);
        iEn = en;
        iRst = rstn;
        cycleNum++;
        modelStep(en, rstn);
        expQA.push_back(expectOf(0, rstn));
        expQB.push_back(expectOf(1, rstn));
        expQC.push_back(expectOf(2, rstn));
    endtask

    task automatic checkOutput(string name, logic [29:0] got, logic [29:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s cyc %0d: got x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b bl=%b, expected x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b bl=%b",
                     name, cycleNum,
                     got[29:18], got[17:6], got[5], got[4], got[3], got[2], got[1], got[0],
                     want[29:18], want[17:6], want[5], want[4], want[3], want[2], want[1], want[0]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQA.size() > 0) checkOutput("dutA", actA, expQA.pop_front());
            if (expQB.size() > 0) checkOutput("dutB", actB, expQB.pop_front());
            if (expQC.size() > 0) checkOutput("dutC", actC, expQC.pop_front());
        end
    end

    initial begin
        bit stalled;
        int guard;
        for (int k = 0; k < 3; k++) begin
            pos[k] = 0;
            stepCnt[k] = 0;
            sinceRst[k] = 0;
        end

        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0);

        // Two full lines of the default raster, with a 5-cycle stall at x=100 of line 1.
        stalled = 1'b0;
        for (int i = 0; i < 1700; i++) begin
            if (pos[0] == 900 && !stalled) begin
                repeat (5) applyStimulus(1'b0, 1'b1);
                stalled = 1'b1;
            end
            applyStimulus(1'b1, 1'b1);
        end

        // Single-cycle reset in the middle of a line.
        guard = 0;
        while (pos[0] % 800 != 700 && guard < 800) begin
            applyStimulus(1'b1, 1'b1);
            guard++;
        end
        applyStimulus(1'b1, 1'b0);
        repeat (30) applyStimulus(1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 499) != 0);
        end

        repeat (1000) applyStimulus(1'b1, 1'b1);

        guard = 0;
        while ((expQA.size() + expQB.size() + expQC.size()) > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if ((expQA.size() + expQB.size() + expQC.size()) > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0",
                     expQA.size() + expQB.size() + expQC.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
